// File: rtl/mcse_lc_ctrl.sv
// Lifecycle transition controller: authenticates a forward state move by hashing
// a credential and comparing against a per-state golden digest, with lockout.
module mcse_lc_ctrl #(
  parameter  int NUM_STATES   = 4,
  parameter  int MAX_ATTEMPTS = 3,
  parameter  int TIMEOUT      = 1024,
  localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
  localparam int AW = $clog2(MAX_ATTEMPTS + 1),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lc_transition_request_in,
  input  logic [255:0]            lc_transition_id,
  input  logic                    lc_authentication_valid,
  input  logic [255:0]            lc_authentication_id,
  input  logic [NUM_STATES*256-1:0] golden_digest,
  output logic                    sha_init,
  output logic [511:0]            sha_block,
  input  logic                    sha_ready,
  input  logic                    sha_digest_valid,
  input  logic [255:0]            sha_digest,
  output logic [SW-1:0]           lc_state,
  output logic                    lc_busy,
  output logic                    lc_done,
  output logic                    lc_fail,
  output logic                    lc_locked,
  output logic [AW-1:0]           attempt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_AUTH, S_HASH_REQ, S_WAIT_DIGEST, S_COMPARE, S_LOCKED
  } state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  lc_state_q, lc_state_d;
  logic [SW-1:0]  target_q, target_d;
  logic [AW-1:0]  attempt_q, attempt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [255:0]   cred_q, cred_d;
  logic [255:0]   digest_q, digest_d;
  logic           done_q, done_d;
  logic           fail_q, fail_d;
  logic           auth_fail;
  logic [AW-1:0]  attempt_inc;
  logic [SW-1:0]  req_tgt;
  logic           tgt_illegal;
  logic           unused_id_bits;

  assign req_tgt        = lc_transition_id[SW-1:0];
  assign unused_id_bits = ^lc_transition_id[255:SW];
  // Only strictly forward moves into an existing state are allowed.
  assign tgt_illegal    = (req_tgt <= lc_state_q) || (32'(req_tgt) >= NUM_STATES);
  assign attempt_inc    = attempt_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    lc_state_d = lc_state_q;
    target_d   = target_q;
    attempt_d  = attempt_q;
    tmo_d      = tmo_q;
    cred_d     = cred_q;
    digest_d   = digest_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    sha_init   = 1'b0;
    auth_fail  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (lc_transition_request_in) begin
          target_d = req_tgt;
          if (tgt_illegal) fail_d  = 1'b1;
          else             state_d = S_WAIT_AUTH;
        end
      end
      S_WAIT_AUTH: begin
        if (lc_authentication_valid) begin
          cred_d  = lc_authentication_id;
          tmo_d   = '0;
          state_d = S_HASH_REQ;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_d     = '0;
          auth_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_HASH_REQ: begin
        if (sha_ready) begin
          sha_init = 1'b1;
          state_d  = S_WAIT_DIGEST;
        end
      end
      S_WAIT_DIGEST: begin
        if (sha_digest_valid) begin
          digest_d = sha_digest;
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (digest_q == golden_digest[int'(target_q)*256 +: 256]) begin
          lc_state_d = target_q;
          attempt_d  = '0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          auth_fail = 1'b1;
        end
      end
      S_LOCKED: ;
      default: state_d = S_IDLE;
    endcase
    // Timeout and digest mismatch share the same attempt accounting.
    if (auth_fail) begin
      attempt_d = attempt_inc;
      fail_d    = 1'b1;
      state_d   = (attempt_inc == AW'(MAX_ATTEMPTS)) ? S_LOCKED : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lc_state_q <= '0;
      target_q   <= '0;
      attempt_q  <= '0;
      tmo_q      <= '0;
      cred_q     <= '0;
      digest_q   <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lc_state_q <= lc_state_d;
      target_q   <= target_d;
      attempt_q  <= attempt_d;
      tmo_q      <= tmo_d;
      cred_q     <= cred_d;
      digest_q   <= digest_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  // Single-block padded message: 256-bit credential, pad bit, length 256.
  assign sha_block   = sha_init ? {cred_q, 1'b1, 191'd0, 64'd256} : '0;
  assign lc_state    = lc_state_q;
  assign attempt_cnt = attempt_q;
  assign lc_done     = done_q;
  assign lc_fail     = fail_q;
  assign lc_locked   = (state_q == S_LOCKED);
  assign lc_busy     = (state_q == S_WAIT_AUTH) || (state_q == S_HASH_REQ) ||
                       (state_q == S_WAIT_DIGEST) || (state_q == S_COMPARE);

endmodule

// File: doc/mcse_lc_ctrl.md
MCSE_LC_CTRL -- requirements
Module: mcse_lc_ctrl

Interface
REQ-001 SHALL have parameter NUM_STATES, default 4: number of lifecycle states; SW = $clog2(NUM_STATES).
REQ-002 SHALL have parameter MAX_ATTEMPTS, default 3: consecutive failures that cause lockout.
REQ-003 SHALL have parameter TIMEOUT, default 1024: cycles allowed in WAIT_AUTH before failure.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port lc_transition_request_in, input, 1: level request; sampled only in IDLE.
REQ-007 SHALL have port lc_transition_id, input, 256: target state in bits [SW-1:0]; upper bits ignored.
REQ-008 SHALL have port lc_authentication_valid, input, 1: lc_authentication_id is valid this cycle.
REQ-009 SHALL have port lc_authentication_id, input, 256: credential to be hashed.
REQ-010 SHALL have port golden_digest, input, NUM_STATES*256: slice k is the expected SHA-256 for entering state k.
REQ-011 SHALL have ports sha_init (output, 1), sha_block (output, 512), sha_ready (input, 1), sha_digest_valid (input, 1), sha_digest (input, 256): hash engine handshake.
REQ-012 SHALL have outputs lc_state (SW), lc_busy (1), lc_done (1), lc_fail (1), lc_locked (1), attempt_cnt ($clog2(MAX_ATTEMPTS+1)).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_AUTH, HASH_REQ, WAIT_DIGEST, COMPARE, LOCKED.
REQ-014 IDLE: on lc_transition_request_in=1, SHALL latch target=lc_transition_id[SW-1:0]; if target <= lc_state or target >= NUM_STATES, SHALL pulse lc_fail next cycle and stay in IDLE; else SHALL enter WAIT_AUTH.
REQ-015 Illegal-target failures SHALL NOT increment attempt_cnt.
REQ-016 WAIT_AUTH: SHALL count cycles from 0; on lc_authentication_valid SHALL latch the credential and enter HASH_REQ; when the counter reaches TIMEOUT-1 without valid, SHALL treat it as an authentication failure.
REQ-017 HASH_REQ: SHALL hold sha_init low until sha_ready=1, then assert sha_init for exactly one cycle and enter WAIT_DIGEST.
REQ-018 sha_block SHALL equal {latched credential, 1'b1, 191'b0, 64'd256} whenever sha_init is asserted, zero otherwise.
REQ-019 WAIT_DIGEST: on sha_digest_valid SHALL latch sha_digest and enter COMPARE; sha_digest_valid in any other state SHALL be ignored.
REQ-020 COMPARE (one cycle): match with golden_digest slice [target] SHALL set lc_state=target, clear attempt_cnt, pulse lc_done, and return to IDLE.
REQ-021 Mismatch or timeout SHALL increment attempt_cnt and pulse lc_fail; if the new count equals MAX_ATTEMPTS SHALL enter LOCKED, else IDLE.
REQ-022 lc_done and lc_fail SHALL be single-cycle pulses, mutually exclusive.
REQ-023 lc_busy SHALL be 1 in WAIT_AUTH, HASH_REQ, WAIT_DIGEST, COMPARE; 0 in IDLE and LOCKED.
REQ-024 LOCKED SHALL be absorbing: lc_locked=1, all requests ignored, sha_init=0; only rst exits.
REQ-025 lc_state SHALL never decrease and SHALL saturate at NUM_STATES-1 (later requests fail as illegal).
REQ-026 A request held high after completion SHALL start a new transaction on the cycle after returning to IDLE.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, lc_state=0, attempt_cnt=0, timeout counter=0, and lc_busy, lc_done, lc_fail, lc_locked, sha_init and sha_block all 0.
REQ-028 Reset mid-transaction (including while sha_init is high, or in LOCKED) SHALL abort it without emitting lc_done or lc_fail.

Verification
REQ-029 Target 1 from state 0, correct credential, sha_ready=1, digest returned 5 cycles later -> one sha_init pulse, lc_done pulse, lc_state=1, attempt_cnt=0.
REQ-030 Target 0 from lc_state=1 -> lc_fail pulse the next cycle, no sha_init, attempt_cnt unchanged.
REQ-031 Three consecutive wrong digests (MAX_ATTEMPTS=3) -> lc_fail after each, attempt_cnt 1,2,3, lc_locked=1; a further request -> no activity.
REQ-032 TIMEOUT=16, no lc_authentication_valid -> lc_fail exactly 16 cycles after entering WAIT_AUTH, attempt_cnt=1.
REQ-033 sha_ready held low 10 cycles in HASH_REQ -> sha_init stays 0, then pulses once in the cycle sha_ready=1; sha_block = credential, 1, zero padding, length 0x100.
REQ-034 rst asserted while in WAIT_DIGEST -> all outputs 0 asynchronously; a late sha_digest_valid is ignored and lc_state=0.
